// File: rtl/sgdma_pkg.sv
// ---------------------------------------------------------------------------
// sgdma_pkg
// Shared definitions for the SGDMA descriptor fetch block: FSM state
// encoding, descriptor word offsets, control-byte bit positions and the
// descriptor record presented to the transfer engine.
// ---------------------------------------------------------------------------
package sgdma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CHECK,
        S_PRESENT,
        S_EXEC,
        S_WRITEBACK
    } sgdma_state_t;

    // Word offsets inside a 4-word descriptor
    localparam logic [1:0] OFF_SRC  = 2'd0;
    localparam logic [1:0] OFF_DST  = 2'd1;
    localparam logic [1:0] OFF_NEXT = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    // Control byte bits
    localparam int CTRL_OWNED = 7;
    localparam int CTRL_EOC   = 6;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  ctrl;
        logic [15:0] len;
    } sgdma_desc_t;

    // Status word written back: ownership returned to software, status from
    // the transfer engine, original length preserved.
    function automatic logic [31:0] wb_word(input logic [7:0]  ctrl,
                                            input logic [7:0]  status,
                                            input logic [15:0] len);
        return {ctrl & 8'h7F, status, len};
    endfunction

endpackage

// File: rtl/sgdma_rd_tracker.sv
// ---------------------------------------------------------------------------
// sgdma_rd_tracker
// Follows in-flight descriptor reads through a READ_LATENCY-deep shift
// register so each returning word can be steered to the right field.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   rd_issue          a read is on the bus this cycle
//   rd_idx            word index (0..3) of that read
//   cap_valid         avm_readdata carries a descriptor word this cycle
//   cap_idx           word index of the returning data
//   cap_last          the control word (last of four) is returning
// ---------------------------------------------------------------------------
module sgdma_rd_tracker
    import sgdma_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_issue,
    input  logic [1:0] rd_idx,
    output logic       cap_valid,
    output logic [1:0] cap_idx,
    output logic       cap_last
);

    logic [READ_LATENCY-1:0] vld_sr;
    logic [1:0]              idx_sr [READ_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                idx_sr[i] <= 2'd0;
            end
        end else begin
            vld_sr[0] <= rd_issue;
            idx_sr[0] <= rd_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                idx_sr[i] <= idx_sr[i-1];
            end
        end
    end

    assign cap_valid = vld_sr[READ_LATENCY-1];
    assign cap_idx   = idx_sr[READ_LATENCY-1];
    assign cap_last  = cap_valid && (cap_idx == OFF_CTRL);

endmodule

// File: rtl/sgdma_descriptor_fetch.sv
// ---------------------------------------------------------------------------
// sgdma_descriptor_fetch
// Avalon-MM master that walks a linked chain of 4-word descriptors in the
// descriptor memory, hands each owned descriptor to the transfer engine,
// waits for completion, optionally writes status back, and follows the
// next pointer.
//
// Build option: SGDMA_DESC_WRITEBACK_EN
//   defined   - status word is written back after every transfer
//   undefined - no writeback; write port tied off, xfer_status unused
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   start, start_ptr, abort           chain control from the CPU
//   busy, chain_done                  chain status
//   avm_address/read/write/byteenable/writedata, avm_readdata
//                                     descriptor memory master port
//   desc_valid, desc_ready, desc_src/dst/len/ctrl
//                                     descriptor handshake to datapath
//   xfer_done, xfer_status            transfer completion from datapath
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no chain active
// FETCH     | issuing reads of words p..p+3
// DRAIN     | waiting for the last read word to return
// CHECK     | decide on ownership / abort
// PRESENT   | desc_valid high, waiting for desc_ready
// EXEC      | transfer in progress, waiting for xfer_done
// WRITEBACK | single write of status word at p+3
// ---------------------------------------------------------------------------
module sgdma_descriptor_fetch
    import sgdma_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_ptr,
    input  logic              abort,
    output logic              busy,
    output logic              chain_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_src,
    output logic [31:0]       desc_dst,
    output logic [15:0]       desc_len,
    output logic [7:0]        desc_ctrl,
    input  logic              xfer_done,
    input  logic [7:0]        xfer_status
);

    sgdma_state_t      state;
    sgdma_desc_t       desc;
    logic [ADDR_W-1:0] cur_ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [1:0]        rd_cnt;

    logic              cap_valid;
    logic [1:0]        cap_idx;
    logic              cap_last;

    sgdma_rd_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_issue  (avm_read),
        .rd_idx    (rd_cnt),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx),
        .cap_last  (cap_last)
    );

    assign desc_src  = desc.src;
    assign desc_dst  = desc.dst;
    assign desc_len  = desc.len;
    assign desc_ctrl = desc.ctrl;

`ifndef SGDMA_DESC_WRITEBACK_EN
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'h0;
    assign avm_writedata  = 32'h0;

    logic unused_status;
    assign unused_status = ^xfer_status;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            desc        <= '0;
            cur_ptr     <= '0;
            next_ptr    <= '0;
            rd_cnt      <= 2'd0;
            busy        <= 1'b0;
            chain_done  <= 1'b0;
            avm_address <= '0;
            avm_read    <= 1'b0;
            desc_valid  <= 1'b0;
`ifdef SGDMA_DESC_WRITEBACK_EN
            avm_write      <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'h0;
`endif
        end else begin
            chain_done <= 1'b0;

            // Returning words are steered by the tag that travelled with the read
            if (cap_valid) begin
                case (cap_idx)
                    OFF_SRC:  desc.src <= avm_readdata;
                    OFF_DST:  desc.dst <= avm_readdata;
                    OFF_NEXT: next_ptr <= avm_readdata[ADDR_W-1:0];
                    default: begin
                        desc.ctrl <= avm_readdata[31:24];
                        desc.len  <= avm_readdata[15:0];
                    end
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        cur_ptr     <= start_ptr;
                        avm_address <= start_ptr;
                        avm_read    <= 1'b1;
                        rd_cnt      <= 2'd0;
                        state       <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (rd_cnt == OFF_CTRL) begin
                        avm_read <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        rd_cnt      <= rd_cnt + 2'd1;
                        avm_address <= avm_address + ADDR_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (cap_last) begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!desc.ctrl[CTRL_OWNED] || abort) begin
                        busy       <= 1'b0;
                        chain_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        desc_valid <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end

                S_PRESENT: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (xfer_done) begin
`ifdef SGDMA_DESC_WRITEBACK_EN
                        avm_write      <= 1'b1;
                        avm_byteenable <= 4'hF;
                        avm_address    <= cur_ptr + ADDR_W'(OFF_CTRL);
                        avm_writedata  <= wb_word(desc.ctrl, xfer_status, desc.len);
                        state          <= S_WRITEBACK;
`else
                        if (desc.ctrl[CTRL_EOC] || abort) begin
                            busy       <= 1'b0;
                            chain_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            cur_ptr     <= next_ptr;
                            avm_address <= next_ptr;
                            avm_read    <= 1'b1;
                            rd_cnt      <= 2'd0;
                            state       <= S_FETCH;
                        end
`endif
                    end
                end

`ifdef SGDMA_DESC_WRITEBACK_EN
                S_WRITEBACK: begin
                    avm_write      <= 1'b0;
                    avm_byteenable <= 4'h0;
                    if (desc.ctrl[CTRL_EOC] || abort) begin
                        busy       <= 1'b0;
                        chain_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cur_ptr     <= next_ptr;
                        avm_address <= next_ptr;
                        avm_read    <= 1'b1;
                        rd_cnt      <= 2'd0;
                        state       <= S_FETCH;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgdma_descriptor_fetch.sv
// ---------------------------------------------------------------------------
// tb_sgdma_descriptor_fetch
// Two instances share one descriptor memory image: READ_LATENCY=1 (main
// tests) and READ_LATENCY=3 (reset-during-drain test). `sel` picks which one
// the stimulus drives and observes.
// ---------------------------------------------------------------------------
module tb_sgdma_descriptor_fetch;

`ifdef SGDMA_DESC_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, desc_ready, xfer_done, sel;
    logic [9:0]  start_ptr;
    logic [7:0]  xfer_status;

    logic        busy_a, done_a, rd_a, wr_a, dv_a;
    logic [9:0]  addr_a;
    logic [3:0]  be_a;
    logic [31:0] wd_a, src_a, dst_a;
    logic [15:0] len_a;
    logic [7:0]  ctrl_a;

    logic        busy_b, done_b, rd_b, wr_b, dv_b;
    logic [9:0]  addr_b;
    logic [3:0]  be_b;
    logic [31:0] wd_b, src_b, dst_b;
    logic [15:0] len_b;
    logic [7:0]  ctrl_b;

    logic [31:0] mem [0:1023];
    logic [31:0] rd1;
    logic [31:0] p3 [0:2];

    sgdma_descriptor_fetch #(.READ_LATENCY(1), .ADDR_W(10)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .start(start & ~sel), .start_ptr(start_ptr),
        .abort(abort), .busy(busy_a), .chain_done(done_a),
        .avm_address(addr_a), .avm_read(rd_a), .avm_write(wr_a),
        .avm_byteenable(be_a), .avm_writedata(wd_a), .avm_readdata(rd1),
        .desc_valid(dv_a), .desc_ready(desc_ready & ~sel),
        .desc_src(src_a), .desc_dst(dst_a), .desc_len(len_a), .desc_ctrl(ctrl_a),
        .xfer_done(xfer_done & ~sel), .xfer_status(xfer_status));

    sgdma_descriptor_fetch #(.READ_LATENCY(3), .ADDR_W(10)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .start(start & sel), .start_ptr(start_ptr),
        .abort(abort), .busy(busy_b), .chain_done(done_b),
        .avm_address(addr_b), .avm_read(rd_b), .avm_write(wr_b),
        .avm_byteenable(be_b), .avm_writedata(wd_b), .avm_readdata(p3[2]),
        .desc_valid(dv_b), .desc_ready(desc_ready & sel),
        .desc_src(src_b), .desc_dst(dst_b), .desc_len(len_b), .desc_ctrl(ctrl_b),
        .xfer_done(xfer_done & sel), .xfer_status(xfer_status));

    always @(posedge clk) begin
        if (rd_a) rd1 <= mem[addr_a];
        p3[0] <= mem[addr_b];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    logic        o_busy, o_done, o_rd, o_wr, o_dv;
    logic [9:0]  o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_src, o_dst;
    logic [15:0] o_len;
    logic [7:0]  o_ctrl;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_rd   = sel ? rd_b   : rd_a;
    assign o_wr   = sel ? wr_b   : wr_a;
    assign o_dv   = sel ? dv_b   : dv_a;
    assign o_addr = sel ? addr_b : addr_a;
    assign o_be   = sel ? be_b   : be_a;
    assign o_wd   = sel ? wd_b   : wd_a;
    assign o_src  = sel ? src_b  : src_a;
    assign o_dst  = sel ? dst_b  : dst_a;
    assign o_len  = sel ? len_b  : len_a;
    assign o_ctrl = sel ? ctrl_b : ctrl_a;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int t0, first_valid, done_cyc, nwr;
    bit stable;

    logic [9:0]  exp_rd   [$];
    logic [87:0] exp_desc [$];
    logic [45:0] exp_wr   [$];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] cur_desc();
        return {o_src, o_dst, o_len, o_ctrl};
    endfunction

    function automatic logic [159:0] all_out();
        return {o_busy, o_done, o_rd, o_wr, o_dv, o_addr, o_be, o_wd, o_src, o_dst, o_len, o_ctrl};
    endfunction

    // Observe the current cycle (inputs already driven), then advance one cycle
    task automatic cyc();
        logic [159:0] e;
        if (o_rd) begin
            e = 160'hDEAD;
            if (exp_rd.size() > 0) e = 160'(exp_rd.pop_front());
            check("rd_addr", o_addr, e);
        end
        if (o_rd && o_wr) check("rd_wr_overlap", {o_rd, o_wr}, 2'b10);
        if (o_dv && desc_ready) begin
            e = 160'hDEAD;
            if (exp_desc.size() > 0) e = 160'(exp_desc.pop_front());
            check("desc", cur_desc(), e);
        end
        if (o_wr) begin
            nwr++;
            if (exp_wr.size() > 0) check("writeback", {o_addr, o_be, o_wd}, exp_wr.pop_front());
        end
        if (o_dv && first_valid < 0) first_valid = cycle;
        if (o_done && done_cyc < 0) done_cyc = cycle;
        @(negedge clk);
        cycle++;
    endtask

    task automatic put_desc(input logic [9:0] p, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] nxt, input logic [7:0] ctrl, input logic [15:0] len);
        mem[p]         = src;
        mem[p + 10'd1] = dst;
        mem[p + 10'd2] = nxt;
        mem[p + 10'd3] = {ctrl, 8'h00, len};
    endtask

    task automatic expect_desc(input logic [9:0] p, input logic [31:0] src, input logic [31:0] dst,
                               input logic [7:0] ctrl, input logic [15:0] len, input logic [7:0] st);
        for (int k = 0; k < 4; k++) exp_rd.push_back(p + 10'(k));
        if (ctrl[7]) exp_desc.push_back({src, dst, len, ctrl});
        if (ctrl[7] && WB) exp_wr.push_back({p + 10'd3, 4'hF, ctrl & 8'h7F, st, len});
    endtask

    task automatic kick(input logic [9:0] ptr);
        first_valid = -1;
        done_cyc    = -1;
        nwr         = 0;
        start_ptr   = ptr;
        start       = 1'b1;
        t0          = cycle;
        cyc();
        start = 1'b0;
        check("busy_after_start", o_busy, 1'b1);
        check("read_after_start", o_rd, 1'b1);
    endtask

    // Acts as the transfer engine until chain_done or the cycle budget runs out
    task automatic service(input int budget, input int hold, input bit abort_exec,
                           input bit poke, input logic [7:0] st, output bit stab);
        int wait_c;
        int exec_c;
        logic [87:0] snap;
        wait_c = 0;
        exec_c = -1;
        stab   = 1'b1;
        snap   = '0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc >= 0) break;
            desc_ready  = 1'b0;
            xfer_done   = 1'b0;
            start       = 1'b0;
            xfer_status = st;
            if (o_dv) begin
                if (wait_c == 0) snap = cur_desc();
                else if (cur_desc() !== snap) stab = 1'b0;
                if (poke && wait_c == 3) begin
                    start     = 1'b1;
                    start_ptr = 10'h300;
                end
                if (wait_c >= hold) desc_ready = 1'b1;
                wait_c++;
            end
            if (exec_c >= 0) begin
                exec_c++;
                if (exec_c == 1 && abort_exec) abort = 1'b1;
                if (exec_c == 3) begin
                    xfer_done = 1'b1;
                    exec_c    = -1;
                end
            end
            if (o_dv && desc_ready) begin
                exec_c = 0;
                wait_c = 0;
            end
            cyc();
        end
        desc_ready = 1'b0;
        xfer_done  = 1'b0;
        start      = 1'b0;
        check("chain_done_seen", done_cyc >= 0, 1'b1);
    endtask

    task automatic end_test(input int exp_writes);
        check("reads_left", exp_rd.size(), 0);
        check("descs_left", exp_desc.size(), 0);
        check("writes_left", exp_wr.size(), 0);
        check("write_count", nwr, exp_writes);
        check("busy_after_done", o_busy, 1'b0);
        exp_rd.delete();
        exp_desc.delete();
        exp_wr.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; desc_ready = 1'b0;
        xfer_done = 1'b0; sel = 1'b0; start_ptr = '0; xfer_status = '0;
        first_valid = -1; done_cyc = -1; nwr = 0; t0 = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs_l1", all_out(), '0);
        sel = 1'b1;
        #1;
        check("reset_outputs_l3", all_out(), '0);
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single owned descriptor with end-of-chain
        put_desc(10'h010, 32'hA0A0_1000, 32'hB0B0_2000, 32'h0, 8'hC0, 16'h0100);
        expect_desc(10'h010, 32'hA0A0_1000, 32'hB0B0_2000, 8'hC0, 16'h0100, 8'h01);
        kick(10'h010);
        service(200, 0, 1'b0, 1'b0, 8'h01, stable);
        check("single_valid_latency", first_valid - t0, 7);
        end_test(WB ? 1 : 0);
        repeat (2) cyc();

        // Three-descriptor chain whose middle fetch wraps the address space
        put_desc(10'h3FE, 32'hCAFE_0000, 32'hBEEF_0000, 32'h1234_0020, 8'h80, 16'h0040);
        put_desc(10'h000, 32'h1234_0020, 32'h8000_0040, 32'h0000_03FE, 8'h80, 16'h0011);
        put_desc(10'h020, 32'h5555_0300, 32'h6666_0400, 32'h0000_0000, 8'hC0, 16'h0222);
        expect_desc(10'h000, 32'h1234_0020, 32'h8000_0040, 8'h80, 16'h0011, 8'h5A);
        expect_desc(10'h3FE, 32'hCAFE_0000, 32'hBEEF_0000, 8'h80, 16'h0040, 8'h5A);
        expect_desc(10'h020, 32'h5555_0300, 32'h6666_0400, 8'hC0, 16'h0222, 8'h5A);
        kick(10'h000);
        service(400, 1, 1'b0, 1'b0, 8'h5A, stable);
        end_test(WB ? 3 : 0);
        repeat (2) cyc();

        // First descriptor not owned by hardware
        put_desc(10'h100, 32'h1, 32'h2, 32'h0, 8'h00, 16'h0010);
        expect_desc(10'h100, 32'h1, 32'h2, 8'h00, 16'h0010, 8'h00);
        kick(10'h100);
        service(100, 0, 1'b0, 1'b0, 8'h00, stable);
        check("notowned_done_latency", done_cyc - t0, 7);
        check("notowned_no_valid", first_valid, -1);
        end_test(0);
        repeat (2) cyc();

        // desc_ready held low for 10 cycles, stray start in the meantime
        put_desc(10'h200, 32'h7777_0001, 32'h8888_0002, 32'h0, 8'hC3, 16'h0ABC);
        expect_desc(10'h200, 32'h7777_0001, 32'h8888_0002, 8'hC3, 16'h0ABC, 8'h22);
        kick(10'h200);
        service(200, 10, 1'b0, 1'b1, 8'h22, stable);
        check("desc_stable_while_waiting", stable, 1'b1);
        end_test(WB ? 1 : 0);
        repeat (3) cyc();

        // Abort during EXEC of descriptor 1 of a two-deep chain
        put_desc(10'h040, 32'h0404_0000, 32'h0505_0000, 32'h0000_0050, 8'h80, 16'h0033);
        put_desc(10'h050, 32'h0606_0000, 32'h0707_0000, 32'h0, 8'hC0, 16'h0044);
        expect_desc(10'h040, 32'h0404_0000, 32'h0505_0000, 8'h80, 16'h0033, 8'h7E);
        kick(10'h040);
        service(200, 0, 1'b1, 1'b0, 8'h7E, stable);
        abort = 1'b0;
        end_test(WB ? 1 : 0);
        repeat (2) cyc();

        // READ_LATENCY=3: reset during DRAIN, then a clean restart
        sel = 1'b1;
        put_desc(10'h080, 32'h0808_1111, 32'h0909_2222, 32'h0, 8'hC0, 16'h0123);
        for (int k = 0; k < 4; k++) exp_rd.push_back(10'h080 + 10'(k));
        kick(10'h080);
        repeat (5) cyc();
        check("busy_in_drain", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_out(), '0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        check("reads_before_restart", exp_rd.size(), 0);
        expect_desc(10'h080, 32'h0808_1111, 32'h0909_2222, 8'hC0, 16'h0123, 8'h33);
        kick(10'h080);
        service(200, 0, 1'b0, 1'b0, 8'h33, stable);
        check("l3_valid_latency", first_valid - t0, 9);
        end_test(WB ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgdma_descriptor_fetch.md
# sgdma_descriptor_fetch

Avalon-MM master that walks a linked chain of 4-word DMA descriptors stored in the 1024×32 on-chip descriptor memory: fetches each descriptor, presents it to the DMA datapath over a valid/ready handshake, waits for completion, writes status back into the descriptor, then follows the next pointer. It sits between the descriptor memory's master-side port and the SGDMA transfer engine; the Nios II CPU builds the chain and pulses `start`.

## Interface
- `READ_LATENCY`, 1: fixed memory read latency in cycles, range 1–4.
- `ADDR_W`, 10: word-address width of the descriptor memory.

- `clk`  in  1  system clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begin a chain at `start_ptr`. Ignored while `busy`=1.
- `start_ptr`  in  ADDR_W  word address of the first descriptor.
- `abort`  in  1  level; stop the chain at the next descriptor boundary.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `chain_done`  out  1  one-cycle pulse on return to IDLE.
- `avm_address`  out  ADDR_W  master word address.
- `avm_read`  out  1  read strobe, one word per cycle, no waitrequest.
- `avm_write`  out  1  write strobe, single cycle.
- `avm_byteenable`  out  4  always 4'hF during a write.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  read data, valid `READ_LATENCY` cycles after `avm_read`.
- `desc_valid`  out  1  descriptor presented.
- `desc_ready`  in  1  datapath accepts the descriptor.
- `desc_src`, `desc_dst`  out  32  source and destination byte addresses.
- `desc_len`  out  16  transfer length in bytes.
- `desc_ctrl`  out  8  control byte.
- `xfer_done`  in  1  one-cycle pulse; transfer for the accepted descriptor has finished.
- `xfer_status`  in  8  status byte, sampled with `xfer_done`.

## Operation
- Descriptor layout at word offset p: p+0 src, p+1 dst, p+2 next pointer (bits [ADDR_W-1:0] used, rest ignored), p+3 = {ctrl[7:0], status[7:0], len[15:0]}. ctrl[7] = OWNED_BY_HW; ctrl[6] = END_OF_CHAIN.
- Offset addition wraps modulo 2^ADDR_W.
- States:
  - IDLE → FETCH on `start`.
  - FETCH: issues 4 reads on consecutive cycles at p..p+3. → DRAIN after the 4th read.
  - DRAIN: waits until all 4 words are captured, using a latency shift register tagged with word index. → CHECK.
  - CHECK: OWNED=0 or `abort` → IDLE. Otherwise → PRESENT.
  - PRESENT: `desc_valid`=1. On `desc_valid & desc_ready` → EXEC.
  - EXEC: waits for `xfer_done`. → WRITEBACK.
  - WRITEBACK: writes word p+3 once. → IDLE if END_OF_CHAIN or `abort`; otherwise p←next and → FETCH.
- Writeback data: {ctrl with bit7 cleared, `xfer_status`, original len}.
- `desc_*` outputs are stable from CHECK until leaving EXEC.
- `abort` sampled in PRESENT does not withdraw `desc_valid`. Abort takes effect only in CHECK or WRITEBACK.
- `xfer_done` is ignored outside EXEC. `desc_ready` is ignored outside PRESENT.
- `avm_read` and `avm_write` are never asserted in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, pointer 0.
- Reset mid-chain aborts immediately; a partial write never occurs because writes are single-cycle.
- `start` in cycle t → `avm_read` in t+1..t+4 → last word captured at t+4+`READ_LATENCY` → CHECK next cycle → `desc_valid` at t+6+`READ_LATENCY`.
- `xfer_done` in cycle u → `avm_write` in cycle u+1 → next `avm_read` in u+2.
- A chain of one non-owned descriptor: `chain_done` at t+6+`READ_LATENCY`, no write issued.

## Configuration
- `SGDMA_DESC_WRITEBACK_EN` defined: WRITEBACK state as above.
- Undefined: WRITEBACK is removed.
  - EXEC goes directly to FETCH, or to IDLE under the END_OF_CHAIN/abort rules.
  - `avm_write`, `avm_writedata` and `avm_byteenable` are tied to 0.
  - `xfer_status` is unused.

## Structure
- Shared package `sgdma_pkg`:
  - state enum
  - word offset constants SRC/DST/NEXT/CTRL = 0..3
  - control bit indices OWNED=7, EOC=6
  - descriptor struct
- One sub-module `sgdma_rd_tracker`: READ_LATENCY-deep shift register carrying valid and word index for in-flight reads, plus the capture-complete flag.

## Test plan
- Single descriptor at 0x010, ctrl=0xC0 (OWNED|EOC), len=0x0100, READ_LATENCY=1:
  - src/dst/len presented;
  - after `xfer_done` with status 0x01, word 0x013 reads {0x40,0x01,0x0100};
  - `chain_done` pulses.
- Three-descriptor chain 0x000→0x3FE→0x020: the 0x3FE fetch wraps, reading 0x3FE, 0x3FF, 0x000, 0x001; all three descriptors are presented in order.
- First descriptor ctrl=0x00: no `desc_valid`, no write, `chain_done` 7 cycles after `start`.
- `desc_ready` held low for 10 cycles: `desc_*` remain stable; a `start` pulse issued meanwhile is ignored.
- `abort` asserted during EXEC of descriptor 1 of a 2-deep chain:
  - descriptor 1 writeback still occurs;
  - descriptor 2 is not fetched.
- READ_LATENCY=3 and `reset_n` dropped during DRAIN: all outputs 0 asynchronously; a fresh `start` after release fetches correctly.
